// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO register unit for a MIPS core: launches MULT/MULTU on an external
// pipelined multiplier, commits its product to HI/LO, and serves MTHI/MTLO.
module mips_cpu_hilo_unit #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mul_start,
  input  logic        mul_sign,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_sign,
  input  logic [63:0] mult_product,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        rd_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [31:0]       hi_r, hi_nxt_s;
  logic [31:0]       lo_r, lo_nxt_s;
  logic [31:0]       mult_a_r, mult_a_nxt_s;
  logic [31:0]       mult_b_r, mult_b_nxt_s;
  logic              mult_sign_r, mult_sign_nxt_s;
  logic              done_r, done_nxt_s;
  logic              mt_write_s;
  logic              commit_s;

  assign mt_write_s = mthi | mtlo;
  // A commit needs the full latency elapsed with nothing overriding this edge.
  assign commit_s   = (state_r == WAIT) && (cnt_r == CNT_ZERO) &&
                      !mul_start && !mt_write_s;

  // State, counter and architectural/datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      hi_r        <= 32'h0000_0000;
      lo_r        <= 32'h0000_0000;
      mult_a_r    <= 32'h0000_0000;
      mult_b_r    <= 32'h0000_0000;
      mult_sign_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hi_r        <= hi_nxt_s;
      lo_r        <= lo_nxt_s;
      mult_a_r    <= mult_a_nxt_s;
      mult_b_r    <= mult_b_nxt_s;
      mult_sign_r <= mult_sign_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  // Next state: a new multiply beats an MT write, which beats the countdown.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (mul_start) begin
      state_nxt_s = WAIT;
      cnt_nxt_s   = CNT_LOAD;
    end else if (mt_write_s) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        WAIT: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        IDLE: begin
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Next values of operand latches, HI/LO and the done pulse.
  always_comb begin
    hi_nxt_s        = hi_r;
    lo_nxt_s        = lo_r;
    mult_a_nxt_s    = mult_a_r;
    mult_b_nxt_s    = mult_b_r;
    mult_sign_nxt_s = mult_sign_r;
    done_nxt_s      = commit_s;
    if (mul_start) begin
      mult_a_nxt_s    = rs_data;
      mult_b_nxt_s    = rt_data;
      mult_sign_nxt_s = mul_sign;
    end else if (mt_write_s) begin
      if (mthi) begin
        hi_nxt_s = wdata;
      end else begin
        hi_nxt_s = hi_r;
      end
      if (mtlo) begin
        lo_nxt_s = wdata;
      end else begin
        lo_nxt_s = lo_r;
      end
    end else if (commit_s) begin
      hi_nxt_s = mult_product[63:32];
      lo_nxt_s = mult_product[31:0];
    end else begin
      hi_nxt_s = hi_r;
      lo_nxt_s = lo_r;
    end
  end

  assign mult_a    = mult_a_r;
  assign mult_b    = mult_b_r;
  assign mult_sign = mult_sign_r;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign done      = done_r;
  assign busy      = (state_r == WAIT);
  assign stall     = rd_req & busy;

endmodule

// File: doc/mips_cpu_hilo_unit.md
MIPS_CPU_HILO_UNIT -- requirements
Module: mips_cpu_hilo_unit

Interface
REQ-001 Parameter: LATENCY, default 1, multiplier output-register latency in cycles; legal 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 mul_start  input  1  issue MULT/MULTU this cycle.
REQ-005 mul_sign  input  1  1 = MULT (signed), 0 = MULTU; sampled with mul_start.
REQ-006 rs_data, rt_data  input  32 each  multiply operands; sampled with mul_start.
REQ-007 mult_a, mult_b  output  32 each  registered operands driven to multiplier a/b.
REQ-008 mult_sign  output  1  registered sign driven to multiplier sign.
REQ-009 mult_product  input  64  multiplier out.
REQ-010 mthi, mtlo  input  1 each  MTHI/MTLO write strobes.
REQ-011 wdata  input  32  write data for mthi/mtlo.
REQ-012 rd_req  input  1  MFHI/MFLO issued this cycle.
REQ-013 hi, lo  output  32 each  architectural HI/LO registers.
REQ-014 busy  output  1  multiply in flight.
REQ-015 stall  output  1  combinational: rd_req AND busy.
REQ-016 done  output  1  one-cycle pulse after HI/LO commit.

Function
REQ-017 States SHALL be IDLE and WAIT, plus a down-counter cnt of width ceil(log2(LATENCY+1)).
REQ-018 mul_start sampled at edge N (any state) SHALL load mult_a<=rs_data, mult_b<=rt_data, mult_sign<=mul_sign, cnt<=LATENCY, state<=WAIT.
REQ-019 mult_a/mult_b/mult_sign SHALL hold their value until the next accepted mul_start.
REQ-020 In WAIT with cnt!=0 and no mul_start/mthi/mtlo, each edge SHALL decrement cnt.
REQ-021 In WAIT with cnt==0 and no mul_start/mthi/mtlo, the edge SHALL write hi<=mult_product[63:32], lo<=mult_product[31:0], state<=IDLE, done<=1.
REQ-022 Commit latency: start sampled at edge N SHALL update hi/lo at edge N+LATENCY+1; busy high from after edge N until after edge N+LATENCY+1.
REQ-023 busy SHALL equal (state==WAIT).
REQ-024 done SHALL be high exactly one cycle after each commit, else 0.
REQ-025 mul_start while busy SHALL abort the pending multiply (no commit) and restart per REQ-018.
REQ-026 mthi/mtlo while IDLE SHALL write wdata to hi/lo respectively at that edge; both asserted writes both.
REQ-027 mthi/mtlo while busy SHALL cancel the pending multiply (state<=IDLE, no commit, done stays 0) and apply the write.
REQ-028 mul_start with mthi/mtlo in same cycle: mul_start SHALL win; the write SHALL be dropped.
REQ-029 rd_req while IDLE SHALL not stall; hi/lo are read directly by the consumer.
REQ-030 rd_req in the commit cycle SHALL stall (busy still 1); the next cycle reads committed values.
REQ-031 HI/LO SHALL be unchanged in any cycle with no commit and no accepted write.

Reset
REQ-032 reset_n=0 at an edge SHALL set hi=0, lo=0, mult_a=0, mult_b=0, mult_sign=0, cnt=0, state=IDLE, done=0; stall=0 while busy=0.
REQ-033 Reset SHALL take priority over mul_start, mthi, mtlo and any pending commit; a multiply in flight is discarded.

Verification
REQ-034 LATENCY=1, mul_start, sign=1, rs=0xFFFFFFFE, rt=3 at edge 0 -> busy 1 after edge 0; hi=0xFFFFFFFF, lo=0xFFFFFFFA after edge 2; done pulse one cycle.
REQ-035 LATENCY=1, sign=0, rs=rt=0xFFFFFFFF -> after edge 2 hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 Start at edge 0, second start (rs=2, rt=5) at edge 1 -> no commit at edge 2; hi=0, lo=10 after edge 3; one done pulse.
REQ-037 Start at edge 0, mthi wdata=0x1234 at edge 1 -> hi=0x1234 after edge 1, lo unchanged, busy 0, no done, no commit at edge 2.
REQ-038 LATENCY=3, start at edge 0, rd_req held high -> stall high through commit cycle, low after edge 4.
REQ-039 Start at edge 0, reset_n=0 at edge 1 -> hi=lo=0, busy=0 after edge 1; no commit at edge 2.
